// File: rtl/shift_pkg.sv
// shift_pkg: types and sizing helpers shared by the serializer and the receive-side blocks.
package shift_pkg;

    typedef enum logic {SER_IDLE, SER_SHIFT} ser_state_t;

    // Returns the bit-counter width for a word of w bits. It never returns less than one bit.
    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/shift_serializer.sv
// shift_serializer: parallel-in, serial-out transmitter with valid/ready input and stallable output.
// The bit at data_in[0] is sent first. A new word can be loaded on the last bit, so words stream with no gap.
module shift_serializer
    import shift_pkg::*;
#(
    parameter int width = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [0:width-1] data_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             out_ready,
    output logic             serial_out,
    output logic             out_valid,
    output logic             out_last
);

    localparam int CW = cnt_width(width);
    localparam logic [CW-1:0] LAST = CW'(width - 1);

    ser_state_t       state_q, state_d;
    logic [0:width-1] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             accept, advance;

    assign in_ready = (state_q == SER_IDLE) || (last_q && out_ready);
    assign accept   = in_valid && in_ready;
    assign advance  = (state_q == SER_SHIFT) && out_ready;

    // The register is cleared on the way back to IDLE, so serial_out reads 0 while idle.
    always_comb begin
        state_d = accept ? SER_SHIFT : (advance && last_q) ? SER_IDLE : state_q;
        shreg_d = accept ? data_in : !advance ? shreg_q : last_q ? '0 : {shreg_q[1:width-1], 1'b0};
        cnt_d   = accept ? '0 : !advance ? cnt_q : last_q ? '0 : cnt_q + 1'b1;
        last_d  = (state_d == SER_SHIFT) && (cnt_d == LAST);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SER_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign serial_out = shreg_q[0];
    assign out_valid  = (state_q == SER_SHIFT);
    assign out_last   = last_q;

endmodule

// File: tb/tb_shift_serializer.sv
// tb_shift_serializer: directed checks of shift_serializer at widths 16, 8 and 2.
module tb_shift_serializer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ordy = 1'b0;
    logic [15:0] d16 = '0;
    logic [7:0]  d8 = '0;
    logic [1:0]  d2 = '0;
    logic        iv16 = 1'b0, iv8 = 1'b0, iv2 = 1'b0;
    logic        rdy16, so16, ov16, ol16;
    logic        rdy8, so8, ov8, ol8;
    logic        rdy2, so2, ov2, ol2;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    shift_serializer #(.width(16)) dut16 (
        .clock(clk), .reset_n(rst_n), .data_in(d16), .in_valid(iv16), .in_ready(rdy16),
        .out_ready(ordy), .serial_out(so16), .out_valid(ov16), .out_last(ol16)
    );
    shift_serializer #(.width(8)) dut8 (
        .clock(clk), .reset_n(rst_n), .data_in(d8), .in_valid(iv8), .in_ready(rdy8),
        .out_ready(ordy), .serial_out(so8), .out_valid(ov8), .out_last(ol8)
    );
    shift_serializer #(.width(2)) dut2 (
        .clock(clk), .reset_n(rst_n), .data_in(d2), .in_valid(iv2), .in_ready(rdy2),
        .out_ready(ordy), .serial_out(so2), .out_valid(ov2), .out_last(ol2)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Checks all 16 bits of word w on dut16 (leftmost literal bit first).
    // The shift stalls for stall_len cycles at bit stall_at.
    // At bit raise_at, in_valid is raised with 16'hFFFF as the next word.
    task automatic word16(input logic [15:0] w, input int stall_at, input int stall_len, input int raise_at);
        for (int k = 0; k < 16; k++) begin
            if (k == raise_at) begin
                d16  = 16'hFFFF;
                iv16 = 1'b1;
            end
            if (k == stall_at) begin
                ordy = 1'b0;
                repeat (stall_len) begin
                    chk($sformatf("stall_bit%0d", k), so16, w[15-k]);
                    chk("stall_valid", ov16, 1);
                    chk("stall_last", ol16, 0);
                    chk("stall_ready", rdy16, 0);
                    step();
                end
                ordy = 1'b1;
            end
            chk($sformatf("bit%0d_of_%h", k, w), so16, w[15-k]);
            chk("valid", ov16, 1);
            chk($sformatf("last_at%0d", k), ol16, k == 15);
            chk($sformatf("ready_at%0d", k), rdy16, k == 15);
            step();
        end
    endtask

    initial begin
        // Hold reset low for 3 cycles; all outputs must be idle.
        repeat (3) @(negedge clk);
        chk("rst_so", so16, 0);
        chk("rst_valid", ov16, 0);
        chk("rst_last", ol16, 0);
        chk("rst_ready", rdy16, 1);
        rst_n = 1'b1;
        ordy  = 1'b1;
        step();

        // Send a single word.
        d16  = 16'b0011010010010010;
        iv16 = 1'b1;
        chk("idle_ready", rdy16, 1);
        step();
        iv16 = 1'b0;
        d16  = 16'h0000;
        word16(16'b0011010010010010, -1, 0, -1);
        chk("single_done_valid", ov16, 0);
        chk("single_done_so", so16, 0);

        // Send two words back-to-back with in_valid held.
        d16  = 16'b0011010010010010;
        iv16 = 1'b1;
        step();
        d16 = 16'b1001001010010110;
        word16(16'b0011010010010010, -1, 0, -1);
        iv16 = 1'b0;
        word16(16'b1001001010010110, -1, 0, -1);
        chk("b2b_done_valid", ov16, 0);

        // Stall for 3 cycles at bit 5, so the word takes 19 cycles.
        d16  = 16'hA5A5;
        iv16 = 1'b1;
        step();
        iv16 = 1'b0;
        word16(16'hA5A5, 5, 3, -1);
        chk("stall_done_valid", ov16, 0);

        // A new word offered while busy is taken only on the last bit.
        d16  = 16'h0000;
        iv16 = 1'b1;
        step();
        iv16 = 1'b0;
        word16(16'h0000, -1, 0, 7);
        iv16 = 1'b0;
        d16  = 16'h0000;
        word16(16'hFFFF, -1, 0, -1);
        chk("busy_done_valid", ov16, 0);

        // Reset in the middle of a word.
        d16  = 16'hFFFF;
        iv16 = 1'b1;
        step();
        iv16 = 1'b0;
        repeat (3) step();
        chk("pre_rst_valid", ov16, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_so", so16, 0);
        chk("midrst_valid", ov16, 0);
        chk("midrst_last", ol16, 0);
        chk("midrst_ready", rdy16, 1);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_valid", ov16, 0);
        chk("post_rst_so", so16, 0);

        // Width 8: expected order is 1,1,0,0,0,1,0,1.
        d8  = 8'b11000101;
        iv8 = 1'b1;
        step();
        iv8 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            logic [7:0] w8 = 8'b11000101;
            chk($sformatf("w8_bit%0d", k), so8, w8[7-k]);
            chk("w8_valid", ov8, 1);
            chk($sformatf("w8_last%0d", k), ol8, k == 7);
            step();
        end
        chk("w8_done_valid", ov8, 0);

        // Width 2: expected order is 1,0.
        d2  = 2'b10;
        iv2 = 1'b1;
        step();
        iv2 = 1'b0;
        chk("w2_bit0", so2, 1);
        chk("w2_last0", ol2, 0);
        chk("w2_ready0", rdy2, 0);
        step();
        chk("w2_bit1", so2, 0);
        chk("w2_last1", ol2, 1);
        chk("w2_ready1", rdy2, 1);
        step();
        chk("w2_done_valid", ov2, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/shift_serializer.md
# shift_serializer

Parallel-in, serial-out transmitter for the shift chain: accepts one `width`-bit word per valid/ready handshake and emits it one bit per clock, `data_in[0]` first, with a downstream stall input. It is the transmit end for the shift-register datapath, which receives and realigns words. Back-to-back words stream with no idle bit between them.

## Interface
- `width`, default 16: word width in bits; legal range 2..64.
- `clock` input 1: sole clock, rising-edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `data_in` input [0:width-1]: parallel word; bit 0 is transmitted first.
- `in_valid` input 1: `data_in` holds a word to send.
- `in_ready` output 1: serializer can accept a word this cycle.
- `out_ready` input 1: downstream consumes `serial_out` this cycle; low stalls the shift.
- `serial_out` output 1: current serial bit.
- `out_valid` output 1: `serial_out` carries a word bit.
- `out_last` output 1: current bit is bit `width-1` of its word.

## Operation
- State register, two states: IDLE and SHIFT. Holding register `shreg[0:width-1]`, bit counter `cnt` of $clog2(width) bits.
- Handshake on input: word accepted at a rising edge where `in_valid && in_ready`.
- `in_ready` is combinational: `(state==IDLE) || (state==SHIFT && out_last && out_ready)`.
- IDLE: `out_valid`=0, `serial_out`=0, `out_last`=0. On accept: `shreg<=data_in`, `cnt<=0`, go SHIFT.
- SHIFT: `out_valid`=1, `serial_out`=`shreg[0]`, `out_last`=(`cnt`==width-1).
  - `out_ready`=1 and not last: `shreg` shifts toward index 0 (zero fill at index width-1), `cnt<=cnt+1`.
  - `out_ready`=1 and last: if `in_valid`, reload `shreg`, `cnt<=0`, stay SHIFT; else go IDLE.
  - `out_ready`=0: hold `shreg`, `cnt`, all outputs unchanged.
- `data_in` is sampled only at accept; later changes have no effect on the word in flight.
- `in_valid` while busy (not last bit) is ignored; the source holds it until `in_ready`.
- Reset mid-word: word in flight discarded; no partial completion after reset release.

## Timing
- Reset values (asynchronous, immediate on `reset_n` low): state IDLE, `shreg`=0, `cnt`=0, `serial_out`=0, `out_valid`=0, `out_last`=0; `in_ready`=1 (follows IDLE).
- Latency: word accepted at edge N -> bit 0 on `serial_out` after edge N, registered; bit k after edge N+k with no stalls.
- `out_last` high during the cycle after edge N+width-1.
- Throughput: exactly `width` cycles per word with continuous `in_valid` and `out_ready`; no gap cycle between words.
- Each stall cycle extends the word by one cycle; bit ordering and count are unaffected.
- Simultaneous last bit + new accept + `out_ready`: next word's bit 0 appears on the very next cycle.
- All outputs except `in_ready` are registered; `in_ready` has a combinational path from `out_ready`.

## Structure
- Shared package `shift_pkg`: `typedef enum logic {SER_IDLE, SER_SHIFT} ser_state_t`, and the bit-counter width helper used by both serializer and the receive-side blocks.
- Single module, no sub-module; counter and shift register inline.

## Test plan
- Reset: hold `reset_n`=0 for 3 cycles -> `serial_out`=0, `out_valid`=0, `out_last`=0, `in_ready`=1; pulse `reset_n` low mid-word -> outputs 0 at once, IDLE after release.
- Single word, width=16: send 16'b0011010010010010, `out_ready`=1 -> bits 0,0,1,1,0,1,0,0,1,0,0,1,0,0,1,0 over 16 cycles, `out_last` only on the 16th, then `out_valid`=0.
- Back-to-back: 16'b0011010010010010 then 16'b1001001010010110 with `in_valid` held -> 32 contiguous valid bits, second word's first bit (1) immediately after first `out_last`, `in_ready` high only on the last-bit cycles.
- Stall: drop `out_ready` for 3 cycles at bit 5 of 16'hA5A5 -> `serial_out`, `out_valid` frozen for 3 cycles, word completes in 19 cycles, bit sequence intact.
- Busy ignore: change `data_in` to 16'hFFFF and hold `in_valid` during bit 7 of 16'h0000 -> 16 zero bits sent, 16'hFFFF accepted only on the `out_last` cycle.
- Width sweep: width=2 and width=8 instances, words 2'b10 and 8'b11000101 -> correct MSB-index-0-first order and `out_last` on bit width-1.
